// File: rtl/array_ram_be_pipe_if.sv
// Bus interface for array_ram_be_pipe: write port, read port, status and parity signals.
// WIDTH/DEPTH must match the RAM instance; address width derives from DEPTH (minimum 1 bit).
//  master : drives write_*/read_en/read_addr/parity_inject, observes read_*/init_done/parity_err
//  slave  : the RAM side
interface array_ram_be_pipe_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned BE   = WIDTH / 8;
  localparam int unsigned ADDR = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic             write_en;
  logic [ADDR-1:0]  write_addr;
  logic [WIDTH-1:0] write_data;
  logic [BE-1:0]    write_be;
  logic             read_en;
  logic [ADDR-1:0]  read_addr;
  logic [WIDTH-1:0] read_data;
  logic             read_valid;
  logic             init_done;
  logic             parity_inject;
  logic             parity_err;

  modport master (
    output write_en, write_addr, write_data, write_be, read_en, read_addr, parity_inject,
    input  read_data, read_valid, init_done, parity_err
  );

  modport slave (
    input  write_en, write_addr, write_data, write_be, read_en, read_addr, parity_inject,
    output read_data, read_valid, init_done, parity_err
  );
endinterface

// File: rtl/array_ram_be_pipe.sv
// Simple-dual-port RAM with per-byte write enables, 1- or 2-stage registered reads with a
// valid strobe, selectable read-during-write policy and a post-reset clear sweep.
// Optional per-byte even parity when the macro ARRAY_RAM_PARITY_EN is defined.
// Ports:
//  clk   : clock, rising edge
//  rst_n : asynchronous active-low reset
//  bus   : array_ram_be_pipe_if.slave (write/read ports, read_valid, init_done, parity)
// RD_LATENCY values other than 2 build the 1-stage read path.
module array_ram_be_pipe #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned RDW_MODE   = 0
) (
  input logic                clk,
  input logic                rst_n,
  array_ram_be_pipe_if.slave bus
);
  localparam int unsigned     BE        = WIDTH / 8;
  localparam int unsigned     ADDR      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR-1:0] LAST_ADDR = ADDR'(DEPTH - 1);
  localparam logic [ADDR:0]   DEPTH_W   = (ADDR + 1)'(DEPTH);

  typedef enum logic {StInit, StRun} state_e;

  state_e          r_state, w_state_next;
  logic [ADDR-1:0] r_cnt, w_cnt_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StInit;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      StInit: begin
        if (r_cnt == LAST_ADDR) begin
          w_state_next = StRun;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + ADDR'(1);
        end
      end
      StRun:   begin end
      default: w_state_next = StInit;
    endcase
  end

  logic w_run, w_wr_in_range, w_rd_in_range, w_wr_fire, w_rd_fire, w_rdw_merge;

  assign w_run         = (r_state == StRun);
  assign w_wr_in_range = ({1'b0, bus.write_addr} < DEPTH_W);
  assign w_rd_in_range = ({1'b0, bus.read_addr} < DEPTH_W);
  assign w_wr_fire     = w_run && bus.write_en && w_wr_in_range;
  assign w_rd_fire     = w_run && bus.read_en;
  // Same-address collision only matters when the new-data policy is selected.
  assign w_rdw_merge   = (RDW_MODE == 1) && w_wr_fire && (bus.write_addr == bus.read_addr);

  // Storage is never reset; the sweep clears it one word per edge.
  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!w_run) begin
      r_mem[r_cnt] <= '0;
    end else if (w_wr_fire) begin
      for (int k = 0; k < BE; k++) begin
        if (bus.write_be[k]) r_mem[bus.write_addr][8*k +: 8] <= bus.write_data[8*k +: 8];
      end
    end
  end

  logic [WIDTH-1:0] w_rd_word;
  logic             w_rd_perr;

  // Out-of-range reads return zero but still produce a valid strobe.
  always_comb begin
    w_rd_word = '0;
    if (w_rd_in_range) begin
      w_rd_word = r_mem[bus.read_addr];
      if (w_rdw_merge) begin
        for (int k = 0; k < BE; k++) begin
          if (bus.write_be[k]) w_rd_word[8*k +: 8] = bus.write_data[8*k +: 8];
        end
      end
    end
  end

`ifdef ARRAY_RAM_PARITY_EN
  logic [BE-1:0] r_par [DEPTH];
  logic [BE-1:0] w_rd_par, w_calc_par;

  // Stored bit is the even-parity bit of the byte, inverted when injection is requested.
  always_ff @(posedge clk) begin
    if (!w_run) begin
      r_par[r_cnt] <= '0;
    end else if (w_wr_fire) begin
      for (int k = 0; k < BE; k++) begin
        if (bus.write_be[k]) begin
          r_par[bus.write_addr][k] <= (^bus.write_data[8*k +: 8]) ^ bus.parity_inject;
        end
      end
    end
  end

  always_comb begin
    w_rd_par   = '0;
    w_calc_par = '0;
    if (w_rd_in_range) begin
      w_rd_par = r_par[bus.read_addr];
      if (w_rdw_merge) begin
        for (int k = 0; k < BE; k++) begin
          if (bus.write_be[k]) w_rd_par[k] = (^bus.write_data[8*k +: 8]) ^ bus.parity_inject;
        end
      end
    end
    for (int k = 0; k < BE; k++) w_calc_par[k] = ^w_rd_word[8*k +: 8];
  end

  assign w_rd_perr = |(w_rd_par ^ w_calc_par);
`else
  logic w_unused_inject;
  assign w_unused_inject = bus.parity_inject;
  assign w_rd_perr       = 1'b0;
`endif

  logic             w_out_valid;
  logic [WIDTH-1:0] w_out_data;
  logic             w_out_perr;

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic             r_p_valid;
      logic [WIDTH-1:0] r_p_data;
      logic             r_p_perr;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_p_valid <= 1'b0;
          r_p_data  <= '0;
          r_p_perr  <= 1'b0;
        end else begin
          r_p_valid <= w_rd_fire;
          r_p_data  <= w_rd_word;
          r_p_perr  <= w_rd_perr;
        end
      end

      assign w_out_valid = r_p_valid;
      assign w_out_data  = r_p_data;
      assign w_out_perr  = r_p_perr;
    end else begin : g_lat1
      assign w_out_valid = w_rd_fire;
      assign w_out_data  = w_rd_word;
      assign w_out_perr  = w_rd_perr;
    end
  endgenerate

  logic [WIDTH-1:0] r_read_data;
  logic             r_read_valid;
  logic             r_parity_err;

  // read_data only loads on a valid word so it holds between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_read_data  <= '0;
      r_read_valid <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_read_valid <= w_out_valid;
      r_parity_err <= w_out_valid && w_out_perr;
      if (w_out_valid) r_read_data <= w_out_data;
    end
  end

  assign bus.read_data  = r_read_data;
  assign bus.read_valid = r_read_valid;
  assign bus.parity_err = r_parity_err;
  assign bus.init_done  = w_run;
endmodule

// File: tb/tb_array_ram_be_pipe.sv
module tb_array_ram_be_pipe;
  parameter int unsigned RD_LATENCY = 1;
  parameter int unsigned RDW_MODE   = 0;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 6;
`ifdef ARRAY_RAM_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef struct {
    logic [15:0] data;
    logic        perr;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  logic [15:0] last_data = '0;

  // Reference memory image and per-byte "stored parity corrupted" flags.
  logic [15:0] m_mem [DEPTH];
  logic [1:0]  m_bad [DEPTH];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  array_ram_be_pipe_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  array_ram_be_pipe #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .RD_LATENCY(RD_LATENCY), .RDW_MODE(RDW_MODE)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i] = '0;
      m_bad[i] = '0;
    end
  endtask

  // Drives one edge worth of stimulus from a negedge, predicts any read result, updates model.
  task automatic do_cycle(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                          input logic [1:0] wbe, input logic re, input logic [2:0] ra,
                          input logic inj);
    exp_t        e;
    logic [15:0] d;
    logic [1:0]  b;
    bus.write_en      = we;
    bus.write_addr    = wa;
    bus.write_data    = wd;
    bus.write_be      = wbe;
    bus.read_en       = re;
    bus.read_addr     = ra;
    bus.parity_inject = inj;
    if (re) begin
      d = '0;
      b = '0;
      if (int'(ra) < DEPTH) begin
        d = m_mem[ra];
        b = m_bad[ra];
        if (RDW_MODE == 1 && we && wa == ra) begin
          for (int k = 0; k < 2; k++) begin
            if (wbe[k]) begin
              d[8*k +: 8] = wd[8*k +: 8];
              b[k]        = inj;
            end
          end
        end
      end
      e.data = d;
      e.perr = PAR_EN && (b != 2'b00);
      e.due  = cyc + int'(RD_LATENCY);
      sb.push_back(e);
    end
    if (we && int'(wa) < DEPTH) begin
      for (int k = 0; k < 2; k++) begin
        if (wbe[k]) begin
          m_mem[wa][8*k +: 8] = wd[8*k +: 8];
          m_bad[wa][k]        = inj;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(1'b0, 3'd0, 16'h0, 2'b00, 1'b0, 3'd0, 1'b0);
  endtask

  // Releases reset at a negedge and counts edges until init_done; junk traffic is applied
  // while the sweep runs and must be ignored.
  task automatic do_init();
    rst_n = 1'b1;
    for (int k = 1; k <= DEPTH + 2; k++) begin
      if (k <= DEPTH) begin
        bus.write_en   = 1'($urandom_range(0, 1));
        bus.write_addr = 3'($urandom_range(0, 7));
        bus.write_data = 16'($urandom);
        bus.write_be   = 2'b11;
        bus.read_en    = 1'($urandom_range(0, 1));
        bus.read_addr  = 3'($urandom_range(0, 7));
      end else begin
        bus.write_en = 1'b0;
        bus.read_en  = 1'b0;
      end
      @(posedge clk);
      #1;
      check($sformatf("init_done_edge%0d", k), 32'(bus.init_done), 32'(k >= DEPTH));
    end
    @(negedge clk);
    model_clear();
  endtask

  // Scoreboard monitor: pops one expectation per read_valid and checks data, parity, timing.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      check("rst_read_valid", 32'(bus.read_valid), 32'd0);
      check("rst_read_data", 32'(bus.read_data), 32'd0);
      check("rst_parity_err", 32'(bus.parity_err), 32'd0);
      last_data = '0;
    end else if (bus.read_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 32'(bus.read_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        check("read_data", 32'(bus.read_data), 32'(e.data));
        check("parity_err", 32'(bus.parity_err), 32'(e.perr));
        check("read_latency", 32'(cyc), 32'(e.due));
        last_data = e.data;
      end
    end else begin
      check("hold_read_data", 32'(bus.read_data), 32'(last_data));
      check("idle_parity_err", 32'(bus.parity_err), 32'd0);
      if (sb.size() > 0 && sb[0].due < cyc) begin
        check("missing_valid", 32'(bus.read_valid), 32'd1);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.write_en      = 1'b0;
    bus.write_addr    = '0;
    bus.write_data    = '0;
    bus.write_be      = '0;
    bus.read_en       = 1'b0;
    bus.read_addr     = '0;
    bus.parity_inject = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    check("rst_init_done", 32'(bus.init_done), 32'd0);

    // Init sweep, then every word reads zero.
    do_init();
    for (int i = 0; i < DEPTH; i++) do_cycle(1'b0, 3'd0, 16'h0, 2'b00, 1'b1, 3'(i), 1'b0);
    idle(3);

    // Full-word writes and back-to-back readback.
    for (int i = 0; i < DEPTH; i++) do_cycle(1'b1, 3'(i), 16'(i * 16'h1111), 2'b11, 1'b0, 3'd0, 1'b0);
    for (int i = 0; i < DEPTH; i++) do_cycle(1'b0, 3'd0, 16'h0, 2'b00, 1'b1, 3'(i), 1'b0);
    idle(3);

    // Byte enables: expect 0xAA55.
    do_cycle(1'b1, 3'd2, 16'hAAAA, 2'b11, 1'b0, 3'd0, 1'b0);
    do_cycle(1'b1, 3'd2, 16'h1155, 2'b01, 1'b0, 3'd0, 1'b0);
    do_cycle(1'b1, 3'd2, 16'hFFFF, 2'b00, 1'b1, 3'd2, 1'b0);
    idle(3);

    // Read during write on the same address, then a follow-up read.
    do_cycle(1'b1, 3'd4, 16'h1234, 2'b11, 1'b0, 3'd0, 1'b0);
    do_cycle(1'b1, 3'd4, 16'hBEEF, 2'b10, 1'b1, 3'd4, 1'b0);
    do_cycle(1'b0, 3'd0, 16'h0, 2'b00, 1'b1, 3'd4, 1'b0);
    idle(3);

    // Parity injection on both bytes of addr 3.
    do_cycle(1'b1, 3'd3, 16'h00FF, 2'b11, 1'b0, 3'd0, 1'b1);
    do_cycle(1'b0, 3'd0, 16'h0, 2'b00, 1'b1, 3'd3, 1'b0);
    idle(3);

    // Out of range: write ignored, reads give zero with valid.
    do_cycle(1'b1, 3'd7, 16'hFFFF, 2'b11, 1'b0, 3'd0, 1'b0);
    do_cycle(1'b1, 3'd6, 16'hFFFF, 2'b11, 1'b1, 3'd7, 1'b0);
    do_cycle(1'b0, 3'd0, 16'h0, 2'b00, 1'b1, 3'd6, 1'b0);
    idle(3);

    // Randomized mixed traffic.
    for (int i = 0; i < 300; i++) begin
      do_cycle(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
               2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
               1'($urandom_range(0, 7) == 0));
    end
    idle(4);

    // Reset while a read is in flight: no valid may ever appear for it.
    do_cycle(1'b1, 3'd1, 16'h5A5A, 2'b11, 1'b0, 3'd0, 1'b0);
    bus.write_en  = 1'b0;
    bus.read_en   = 1'b1;
    bus.read_addr = 3'd1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("abort_read_valid", 32'(bus.read_valid), 32'd0);
    bus.read_en = 1'b0;
    repeat (3) @(negedge clk);
    do_init();
    do_cycle(1'b0, 3'd0, 16'h0, 2'b00, 1'b1, 3'd1, 1'b0);
    idle(4);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
